// File: rtl/mips_pkg.sv
// Shared MIPS R2000 definitions: opcode constants, the fetch NOP word,
// next-PC source encoding and jump-target formation.
package mips_pkg;

  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEQ,
    PC_BR,
    PC_J,
    PC_JR
  } pc_sel_e;

  // J/JAL target: upper nibble of the delay-slot-free PC+4 of the jump itself
  function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] index);
    return {pc4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port plus the redirect requests coming
// back from ID. The master side is the fetch unit.
interface fetch_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        jump_en;
  logic [25:0] jump_index;
  logic        jr_en;
  logic [31:0] jr_addr;
  logic        branch_taken;
  logic [31:0] branch_target;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  jump_en,
    input  jump_index,
    input  jr_en,
    input  jr_addr,
    input  branch_taken,
    input  branch_target
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output jump_en,
    output jump_index,
    output jr_en,
    output jr_addr,
    output branch_taken,
    output branch_target
  );

endinterface

// File: rtl/next_pc_sel.sv
// Next-PC selection: priority mux JR > J/JAL > branch > sequential, plus
// jump-target formation. Purely combinational.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] if_id_pc4_i,
  input  logic        jump_en_i,
  input  logic [25:0] jump_index_i,
  input  logic        jr_en_i,
  input  logic [31:0] jr_addr_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o,
  output logic        redirect_o
);

  pc_sel_e sel;

  assign pc_plus4_o = pc_i + 32'd4;
  assign redirect_o = jr_en_i | jump_en_i | branch_taken_i;

  // Resolve simultaneous redirect requests by fixed priority
  always_comb begin
    sel = PC_SEQ;
    if (jr_en_i) begin
      sel = PC_JR;
    end else if (jump_en_i) begin
      sel = PC_J;
    end else if (branch_taken_i) begin
      sel = PC_BR;
    end
  end

  // Form the address for the selected source
  always_comb begin
    next_pc_o = pc_plus4_o;
    unique case (sel)
      PC_SEQ:  next_pc_o = pc_plus4_o;
      PC_BR:   next_pc_o = branch_target_i;
      PC_J:    next_pc_o = jump_target(if_id_pc4_i, jump_index_i);
      PC_JR:   next_pc_o = jr_addr_i;
      default: next_pc_o = pc_plus4_o;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and
// fetch/flush counters. Taken redirects squash IF/ID to a single bubble.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PCWrite,
  input  logic                If_Id_Write,
  fetch_unit_if.master        bus,
  output logic [31:0]         pc,
  output logic [31:0]         if_id_instr,
  output logic [31:0]         if_id_pc4,
  output logic                if_id_valid,
  output logic [31:0]         link_addr,
  output logic [31:0]         fetch_count,
  output logic [31:0]         flush_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        redirect;
  logic        flush;

  next_pc_sel u_next_pc_sel (
    .pc_i            (pc_q),
    .if_id_pc4_i     (pc4_q),
    .jump_en_i       (bus.jump_en),
    .jump_index_i    (bus.jump_index),
    .jr_en_i         (bus.jr_en),
    .jr_addr_i       (bus.jr_addr),
    .branch_taken_i  (bus.branch_taken),
    .branch_target_i (bus.branch_target),
    .pc_plus4_o      (pc_plus4),
    .next_pc_o       (next_pc),
    .redirect_o      (redirect)
  );

  // A redirect during a PC stall is dropped; ID re-asserts it once unstalled
  assign flush = redirect & PCWrite;

  // PC next state: advance only when the hazard unit allows it
  always_comb begin
    pc_d = pc_q;
    if (PCWrite) begin
      pc_d = next_pc;
    end
  end

  // IF/ID next state: flush beats load beats hold
  always_comb begin
    instr_d       = instr_q;
    pc4_d         = pc4_q;
    valid_d       = valid_q;
    fetch_count_d = fetch_count_q;
    flush_count_d = flush_count_q;
    if (flush) begin
      instr_d       = NOP_WORD;
      pc4_d         = 32'h0;
      valid_d       = 1'b0;
      flush_count_d = flush_count_q + 32'd1;
    end else if (If_Id_Write) begin
      instr_d       = bus.imem_rdata;
      pc4_d         = pc_plus4;
      valid_d       = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      instr_q       <= NOP_WORD;
      pc4_q         <= 32'h0;
      valid_q       <= 1'b0;
      fetch_count_q <= 32'h0;
      flush_count_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc4_q         <= pc4_d;
      valid_q       <= valid_d;
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign pc            = pc_q;
  assign if_id_instr   = instr_q;
  assign if_id_pc4     = pc4_q;
  assign if_id_valid   = valid_q;
  // No delay slot: JAL links to its own PC+4
  assign link_addr     = pc4_q;
  assign fetch_count   = fetch_count_q;
  assign flush_count   = flush_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: reference PC/IF-ID model with a
// scoreboard of expected IF/ID loads, popped as the DUT registers them.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        PCWrite;
  logic        If_Id_Write;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] link_addr;
  logic [31:0] fetch_count;
  logic [31:0] flush_count;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .PCWrite     (PCWrite),
    .If_Id_Write (If_Id_Write),
    .bus         (bus),
    .pc          (pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .link_addr   (link_addr),
    .fetch_count (fetch_count),
    .flush_count (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: distinct word per address
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
  endfunction

  assign bus.imem_rdata = imem_word(bus.imem_addr);

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_pc, exp_instr, exp_pc4, exp_fc, exp_flc;
  logic        exp_valid;
  logic [63:0] sb[$];

  function automatic logic [192:0] dut_state();
    return {pc, if_id_instr, if_id_pc4, if_id_valid, fetch_count, flush_count, link_addr};
  endfunction

  function automatic logic [192:0] exp_state();
    return {exp_pc, exp_instr, exp_pc4, exp_valid, exp_fc, exp_flc, exp_pc4};
  endfunction

  task automatic model_reset();
    exp_pc    = 32'h0;
    exp_instr = 32'h0;
    exp_pc4   = 32'h0;
    exp_valid = 1'b0;
    exp_fc    = 32'h0;
    exp_flc   = 32'h0;
    sb.delete();
  endtask

  task automatic drive_idle();
    bus.jump_en       = 1'b0;
    bus.jump_index    = 26'h0;
    bus.jr_en         = 1'b0;
    bus.jr_addr       = 32'h0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
  endtask

  // Advance the model with the inputs currently driven, then clock the DUT
  task automatic clk_edge();
    logic        redir;
    logic [31:0] tgt;
    logic [63:0] ent;
    redir = bus.jr_en | bus.jump_en | bus.branch_taken;
    if (bus.jr_en)        tgt = bus.jr_addr;
    else if (bus.jump_en) tgt = {exp_pc4[31:28], bus.jump_index, 2'b00};
    else                  tgt = bus.branch_target;
    if (PCWrite && redir) begin
      sb.delete();
      exp_instr = 32'h0;
      exp_pc4   = 32'h0;
      exp_valid = 1'b0;
      exp_flc   = exp_flc + 32'd1;
    end else if (If_Id_Write) begin
      sb.push_back({imem_word(exp_pc), exp_pc + 32'd4});
      exp_valid = 1'b1;
      exp_fc    = exp_fc + 32'd1;
    end
    if (PCWrite) exp_pc = redir ? tgt : exp_pc + 32'd4;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      ent       = sb.pop_front();
      exp_instr = ent[63:32];
      exp_pc4   = ent[31:0];
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    PCWrite = 1'b1;
    If_Id_Write = 1'b1;
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", pc); end
    n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
    n_tests++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", if_id_instr); end
    n_tests++; if (fetch_count !== 32'h0 || flush_count !== 32'h0) begin
      n_fail++; $display("FAIL reset_counts got %h/%h exp 0/0", fetch_count, flush_count);
    end
    n_tests++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_imem_addr got %h exp 0", bus.imem_addr); end
    rst = 1'b1;
    clk_edge();
    n_tests++; if (if_id_pc4 !== 32'h4 || if_id_valid !== 1'b1) begin
      n_fail++; $display("FAIL first_fetch got pc4=%h v=%b exp pc4=4 v=1", if_id_pc4, if_id_valid);
    end
    n_tests++; if (dut_state() !== exp_state()) begin n_fail++; $display("FAIL first_state got %h exp %h", dut_state(), exp_state()); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 2; i++) begin
      clk_edge();
      n_tests++; if (dut_state() !== exp_state()) begin n_fail++; $display("FAIL seq%0d got %h exp %h", i, dut_state(), exp_state()); end
    end
    n_tests++; if (pc !== 32'hC || fetch_count !== 32'd3 || flush_count !== 32'd0) begin
      n_fail++; $display("FAIL seq_end got pc=%h fc=%0d flc=%0d exp pc=c fc=3 flc=0", pc, fetch_count, flush_count);
    end
  endtask

  task automatic test_jal();
    bus.jump_en = 1'b1;
    bus.jump_index = 26'h3;
    n_tests++; if (link_addr !== exp_pc4) begin n_fail++; $display("FAIL jal_link got %h exp %h", link_addr, exp_pc4); end
    clk_edge();
    n_tests++; if (pc !== 32'hC || if_id_valid !== 1'b0 || flush_count !== 32'd1) begin
      n_fail++; $display("FAIL jal_redirect got pc=%h v=%b flc=%0d exp pc=c v=0 flc=1", pc, if_id_valid, flush_count);
    end
    drive_idle();
    clk_edge();
    n_tests++; if (if_id_pc4 !== 32'h10 || dut_state() !== exp_state()) begin
      n_fail++; $display("FAIL jal_target_fetch got %h exp %h", dut_state(), exp_state());
    end
  endtask

  task automatic test_stall();
    PCWrite = 1'b0;
    If_Id_Write = 1'b0;
    bus.jump_en = 1'b1;
    bus.jump_index = 26'h10;
    for (int i = 0; i < 2; i++) begin
      clk_edge();
      n_tests++; if (dut_state() !== exp_state()) begin n_fail++; $display("FAIL stall%0d got %h exp %h", i, dut_state(), exp_state()); end
    end
    PCWrite = 1'b1;
    If_Id_Write = 1'b1;
    clk_edge();
    n_tests++; if (pc !== 32'h40 || flush_count !== 32'd2 || dut_state() !== exp_state()) begin
      n_fail++; $display("FAIL stall_release got %h exp %h", dut_state(), exp_state());
    end
    drive_idle();
    PCWrite = 1'b0;
    clk_edge();
    n_tests++; if (dut_state() !== exp_state()) begin n_fail++; $display("FAIL pc_stall_load got %h exp %h", dut_state(), exp_state()); end
    PCWrite = 1'b1;
    clk_edge();
    n_tests++; if (dut_state() !== exp_state()) begin n_fail++; $display("FAIL reload got %h exp %h", dut_state(), exp_state()); end
  endtask

  task automatic test_priority();
    bus.jr_en = 1'b1;
    bus.jr_addr = 32'h40;
    bus.jump_en = 1'b1;
    bus.jump_index = 26'h30;
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h80;
    clk_edge();
    n_tests++; if (pc !== 32'h40 || dut_state() !== exp_state()) begin n_fail++; $display("FAIL prio_jr got %h exp %h", dut_state(), exp_state()); end
    bus.jr_en = 1'b0;
    bus.jump_en = 1'b0;
    bus.branch_taken = 1'b0;
    clk_edge();
    bus.jump_en = 1'b1;
    bus.branch_taken = 1'b1;
    clk_edge();
    n_tests++; if (pc !== 32'hC0 || dut_state() !== exp_state()) begin n_fail++; $display("FAIL prio_j got %h exp %h", dut_state(), exp_state()); end
    bus.jump_en = 1'b0;
    bus.branch_taken = 1'b0;
    clk_edge();
    bus.branch_taken = 1'b1;
    clk_edge();
    n_tests++; if (pc !== 32'h80 || dut_state() !== exp_state()) begin n_fail++; $display("FAIL prio_br got %h exp %h", dut_state(), exp_state()); end
    drive_idle();
    clk_edge();
  endtask

  task automatic test_wrap();
    bus.jr_en = 1'b1;
    bus.jr_addr = 32'hFFFF_FFF8;
    clk_edge();
    drive_idle();
    clk_edge();
    bus.jump_en = 1'b1;
    bus.jump_index = 26'h5;
    clk_edge();
    n_tests++; if (pc !== 32'hF000_0014 || dut_state() !== exp_state()) begin
      n_fail++; $display("FAIL jump_upper got %h exp %h", dut_state(), exp_state());
    end
    drive_idle();
    clk_edge();
    bus.jr_en = 1'b1;
    bus.jr_addr = 32'hFFFF_FFFC;
    clk_edge();
    drive_idle();
    clk_edge();
    n_tests++; if (pc !== 32'h0 || if_id_pc4 !== 32'h0 || dut_state() !== exp_state()) begin
      n_fail++; $display("FAIL pc_wrap got %h exp %h", dut_state(), exp_state());
    end
  endtask

  task automatic test_count_wrap();
    PCWrite = 1'b0;
    If_Id_Write = 1'b0;
    @(negedge clk);
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    exp_fc = 32'hFFFF_FFFF;
    If_Id_Write = 1'b1;
    clk_edge();
    n_tests++; if (fetch_count !== 32'h0 || dut_state() !== exp_state()) begin
      n_fail++; $display("FAIL fetch_count_wrap got %h exp %h", dut_state(), exp_state());
    end
    PCWrite = 1'b1;
  endtask

  task automatic test_async_reset();
    PCWrite = 1'b0;
    bus.jump_en = 1'b1;
    bus.jump_index = 26'h2;
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    n_tests++; if (dut_state() !== exp_state() || bus.imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL async_reset got %h exp %h", dut_state(), exp_state());
    end
    @(negedge clk);
    rst = 1'b1;
    PCWrite = 1'b1;
    drive_idle();
    clk_edge();
    n_tests++; if (dut_state() !== exp_state()) begin n_fail++; $display("FAIL post_reset got %h exp %h", dut_state(), exp_state()); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jal();
    test_stall();
    test_priority();
    test_wrap();
    test_count_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
